fifo_rd_stream: RTL and testbench

- Read-side drain stage that sits directly downstream of the synchronous FIFO.
- Turns the FIFO's rden/rddata port (1-cycle read latency, empty flag) into a valid/ready stream for the consumer.
- Prefetches into a small output buffer so that one word per cycle is sustained. No combinational path runs from i_m_ready to o_fifo_rden.
- Provides a synchronous flush and a running transfer counter.

---
 rtl/fifo_rd_stream.sv | 91 +++++++++
 tb/tb_fifo_rd_stream.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// Read-side drain stage for the synchronous FIFO: prefetches into a small circular
// buffer and presents the words as a valid/ready stream, with flush and a transfer counter.
module fifo_rd_stream #(
  parameter int DATA_W    = 8,
  parameter int BUF_DEPTH = 3,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_fifo_empty,
  input  logic [DATA_W-1:0] i_fifo_rddata,
  output logic              o_fifo_rden,
  output logic              o_m_valid,
  input  logic              i_m_ready,
  output logic [DATA_W-1:0] o_m_data,
  input  logic              i_flush,
  output logic [CNT_W-1:0]  o_xfer_cnt
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);
  localparam logic [OCC_W:0]   DEPTH_C  = (OCC_W + 1)'(BUF_DEPTH);

  logic [DATA_W-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_ptr_nx, wr_ptr_nx;
  logic [OCC_W-1:0]  occ, occ_nx;
  logic              inflight;
  logic              push, pop, m_valid;
  logic [DATA_W-1:0] m_data, head_nx;
  logic [CNT_W-1:0]  xfer_cnt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Credit covers both buffered words and the one still in flight from the FIFO.
  assign o_fifo_rden = !i_fifo_empty && !i_flush && rstn &&
                       (({1'b0, occ} + (OCC_W + 1)'(inflight)) < DEPTH_C);

  assign m_valid = (occ != '0);
  assign push    = inflight && !i_flush;
  assign pop     = m_valid && i_m_ready;

  // Head of the buffer after this cycle's push/pop, registered so o_m_data holds when empty.
  always_comb begin
    rd_ptr_nx = rd_ptr;
    wr_ptr_nx = wr_ptr;
    occ_nx    = occ;
    head_nx   = m_data;
    if (i_flush) begin
      rd_ptr_nx = '0;
      wr_ptr_nx = '0;
      occ_nx    = '0;
    end else begin
      if (push) wr_ptr_nx = ptr_inc(wr_ptr);
      if (pop)  rd_ptr_nx = ptr_inc(rd_ptr);
      occ_nx = occ + OCC_W'(push) - OCC_W'(pop);
      if (occ_nx != '0)
        head_nx = (push && (rd_ptr_nx == wr_ptr)) ? i_fifo_rddata : mem[rd_ptr_nx];
    end
  end

  // Capture stage: FIFO return lands in the slot reserved by the credit.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_fifo_rddata;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ      <= '0;
      inflight <= 1'b0;
      m_data   <= '0;
      xfer_cnt <= '0;
    end else begin
      rd_ptr   <= rd_ptr_nx;
      wr_ptr   <= wr_ptr_nx;
      occ      <= occ_nx;
      inflight <= o_fifo_rden;
      m_data   <= head_nx;
      xfer_cnt <= xfer_cnt + CNT_W'(pop);
    end
  end

  assign o_m_valid  = m_valid;
  assign o_m_data   = m_data;
  assign o_xfer_cnt = xfer_cnt;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: behavioural FIFO feeding the DUT, scoreboard on the stream,
// and a CNT_W=4 twin instance for the counter wrap.
module tb_fifo_rd_stream;

  logic        clk = 1'b0;
  logic        rstn, ready, flush;
  logic        empty, rden, valid, rden4, valid4;
  logic [7:0]  rddata, data, data4;
  logic [15:0] cnt;
  logic [3:0]  cnt4;

  logic [7:0]  fmem [0:1023];
  int          fwr = 0;
  int          frd = 0;
  int          cyc = 0;
  int          ndel = 0;
  int          ndrop = 0;
  int          n_chk = 0;
  int          n_err = 0;
  int          del_cyc [0:1023];
  logic [7:0]  exp_q [$];

  always #5 clk = ~clk;

  fifo_rd_stream #(.DATA_W(8), .BUF_DEPTH(3), .CNT_W(16)) u_dut (
    .clk(clk), .rstn(rstn), .i_fifo_empty(empty), .i_fifo_rddata(rddata),
    .o_fifo_rden(rden), .o_m_valid(valid), .i_m_ready(ready), .o_m_data(data),
    .i_flush(flush), .o_xfer_cnt(cnt));

  fifo_rd_stream #(.DATA_W(8), .BUF_DEPTH(3), .CNT_W(4)) u_dut4 (
    .clk(clk), .rstn(rstn), .i_fifo_empty(empty), .i_fifo_rddata(rddata),
    .o_fifo_rden(rden4), .o_m_valid(valid4), .i_m_ready(ready), .o_m_data(data4),
    .i_flush(flush), .o_xfer_cnt(cnt4));

  // Behavioural FIFO with one-cycle read latency.
  assign empty = (frd == fwr);
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rden) begin
      rddata <= fmem[frd[9:0]];
      frd    <= frd + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fifo_push(input logic [7:0] v);
    fmem[fwr[9:0]] = v;
    fwr++;
  endtask

  // One cycle: monitor at the falling edge, then return 1ns after the next rising edge.
  task automatic tick();
    @(negedge clk);
    chk("no_underflow", {31'b0, rden & empty}, 0);
    chk("credit", {31'b0, (frd + int'(rden) - ndel - ndrop) <= 3}, 1);
    chk("twin_rden", {31'b0, rden4}, {31'b0, rden});
    chk("twin_valid", {31'b0, valid4}, {31'b0, valid});
    chk("twin_data", {24'b0, data4}, {24'b0, data});
    if (valid && ready) begin
      if (exp_q.size() == 0) chk("sb_extra", exp_q.size(), 1);
      else                   chk("sb_data", {24'b0, data}, {24'b0, exp_q.pop_front()});
      del_cyc[ndel[9:0]] = cyc;
      ndel++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_del(input int n, input int budget);
    for (int i = 0; i < budget && ndel < n; i++) tick();
    chk("drain", ndel, n);
  endtask

  int c0, base, frd0;
  logic [15:0] cnt_b;
  logic [2:0]  seen;

  initial begin
    rstn = 1'b0; ready = 1'b1; flush = 1'b0;
    tick(); tick();
    chk("rst_data", {24'b0, data}, 0);
    rstn = 1'b1;

    // Idle with empty FIFO
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_rden", {31'b0, rden}, 0);
      chk("idle_valid", {31'b0, valid}, 0);
      chk("idle_cnt", {16'b0, cnt}, 0);
    end

    // Back-to-back burst of 16
    c0 = cyc; base = ndel;
    for (int i = 1; i <= 16; i++) begin fifo_push(8'(i)); exp_q.push_back(8'(i)); end
    #1 chk("burst_rden0", {31'b0, rden}, 1);
    wait_del(base + 16, 40);
    chk("burst_first", del_cyc[base[9:0]], c0 + 2);
    chk("burst_last", del_cyc[(base + 15) % 1024], c0 + 17);
    chk("burst_cnt", {16'b0, cnt}, 16);
    chk("burst_cnt4", {28'b0, cnt4}, 0);

    // Back-pressure: only three reads issued
    ready = 1'b0; frd0 = frd; base = ndel;
    for (int i = 1; i <= 8; i++) begin fifo_push(8'(i)); exp_q.push_back(8'(i)); end
    repeat (8) tick();
    chk("bp_reads", frd - frd0, 3);
    chk("bp_rden", {31'b0, rden}, 0);
    chk("bp_valid", {31'b0, valid}, 1);
    chk("bp_data", {24'b0, data}, 8'h01);
    tick(); tick();
    chk("bp_data_hold", {24'b0, data}, 8'h01);
    ready = 1'b1;
    wait_del(base + 8, 30);
    chk("bp_reads_all", frd - frd0, 8);

    // Random ready with concurrent writes
    base = ndel;
    for (int n = 0; n < 200; ) begin
      if ($urandom_range(0, 1) == 1) begin
        logic [7:0] v;
        v = 8'($urandom_range(0, 255));
        fifo_push(v); exp_q.push_back(v); n++;
      end
      ready = 1'($urandom_range(0, 1));
      tick();
    end
    ready = 1'b1;
    wait_del(base + 200, 400);
    chk("rand_cnt", {16'b0, cnt}, ndel);

    // Flush with two buffered words and one in flight
    ready = 1'b0; base = ndel;
    for (int i = 8'h21; i <= 8'h26; i++) fifo_push(8'(i));
    exp_q.push_back(8'h24); exp_q.push_back(8'h25); exp_q.push_back(8'h26);
    tick(); tick(); tick();
    chk("flA_valid_pre", {31'b0, valid}, 1);
    chk("flA_data_pre", {24'b0, data}, 8'h21);
    cnt_b = cnt; flush = 1'b1;
    #1 chk("flA_rden", {31'b0, rden}, 0);
    tick();
    flush = 1'b0; ndrop += 3;
    chk("flA_valid", {31'b0, valid}, 0);
    chk("flA_cnt", {16'b0, cnt}, {16'b0, cnt_b});
    ready = 1'b1;
    wait_del(base + 3, 20);

    // Flush while streaming: handshake in the flush cycle still counts
    base = ndel;
    for (int i = 8'h31; i <= 8'h34; i++) fifo_push(8'(i));
    exp_q.push_back(8'h31); exp_q.push_back(8'h32); exp_q.push_back(8'h34);
    tick(); tick(); tick();
    chk("flB_rden_pre", {31'b0, rden}, 1);
    chk("flB_data_pre", {24'b0, data}, 8'h32);
    cnt_b = cnt; flush = 1'b1;
    #1 chk("flB_rden", {31'b0, rden}, 0);
    tick();
    flush = 1'b0; ndrop += 1;
    chk("flB_cnt", {16'b0, cnt}, {16'b0, cnt_b} + 1);
    chk("flB_valid", {31'b0, valid}, 0);
    wait_del(base + 3, 20);

    // Counter wrap on the CNT_W=4 twin
    rstn = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    chk("wr_rst_cnt", {16'b0, cnt}, 0);
    chk("wr_rst_data", {24'b0, data}, 0);
    base = ndel; seen = 3'b000;
    for (int i = 8'h41; i <= 8'h51; i++) begin fifo_push(8'(i)); exp_q.push_back(8'(i)); end
    for (int i = 0; i < 60 && seen != 3'b111; i++) begin
      tick();
      if (cnt == 16'd15) begin chk("wrap15", {28'b0, cnt4}, 15); seen[0] = 1'b1; end
      if (cnt == 16'd16) begin chk("wrap0", {28'b0, cnt4}, 0); seen[1] = 1'b1; end
      if (cnt == 16'd17) begin chk("wrap1", {28'b0, cnt4}, 1); seen[2] = 1'b1; end
    end
    chk("wrap_seen", {29'b0, seen}, 3'b111);
    wait_del(base + 17, 10);

    // Reset mid-stream with a word in flight
    ready = 1'b0; base = ndel;
    for (int i = 8'h61; i <= 8'h66; i++) fifo_push(8'(i));
    exp_q.push_back(8'h64); exp_q.push_back(8'h65); exp_q.push_back(8'h66);
    tick(); tick(); tick();
    chk("mr_valid_pre", {31'b0, valid}, 1);
    chk("mr_data_pre", {24'b0, data}, 8'h61);
    rstn = 1'b0;
    #1 chk("mr_rden", {31'b0, rden}, 0);
    tick();
    ndrop += 3;
    chk("mr_rden_rst", {31'b0, rden}, 0);
    chk("mr_valid", {31'b0, valid}, 0);
    chk("mr_data", {24'b0, data}, 0);
    chk("mr_cnt", {16'b0, cnt}, 0);
    chk("mr_cnt4", {28'b0, cnt4}, 0);
    tick();
    rstn = 1'b1; ready = 1'b1;
    wait_del(base + 3, 20);
    chk("mr_cnt_after", {16'b0, cnt}, 3);

    tick(); tick();
    chk("end_sb_empty", exp_q.size(), 0);
    chk("end_valid", {31'b0, valid}, 0);
    chk("end_rden", {31'b0, rden}, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
